// File: rtl/pipe_hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_hilo_pkg
// Brief  : Op/writeback codes, FSM state type and divide sign-fix helper for
//          the HI/LO unit.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LINK = 3'd2;
  localparam logic [2:0] WB_HI   = 3'd3;
  localparam logic [2:0] WB_LO   = 3'd4;

  localparam logic [1:0] MUL_SET = 2'd0;
  localparam logic [1:0] MUL_ADD = 2'd1;
  localparam logic [1:0] MUL_SUB = 2'd2;

  // Widest DATA_W the sign-fix helper supports.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic [MAX_W-1:0] fix_sign(input logic [MAX_W-1:0] i_mag,
                                                input logic             i_neg);
    return i_neg ? (~i_mag + 1'b1) : i_mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hilo_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hilo_if
// Brief  : EX/MEM-side bus of the HI/LO unit (ops, operands, writeback, status).
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hilo_if #(
  parameter int DATA_W = 32
) ();
  logic              op_valid;
  logic [3:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [2:0]        ex_mem_wb_sel;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc;
  logic              mem_wb_sel;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ex_mem_wb_data;
  logic [DATA_W-1:0] mem_wb_data;
  logic              busy;
  logic              stall;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output op_valid, op, src_a, src_b, ex_mem_wb_sel, alu_result, pc,
           mem_wb_sel, mem_data,
    input  ex_mem_wb_data, mem_wb_data, busy, stall, hi_out, lo_out
  );

  modport slave (
    input  op_valid, op, src_a, src_b, ex_mem_wb_sel, alu_result, pc,
           mem_wb_sel, mem_data,
    output ex_mem_wb_data, mem_wb_data, busy, stall, hi_out, lo_out
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hilo_div.sv
`default_nettype none
// ============================================================================
// Module : pipe_hilo_div
// Brief  : Iterative restoring divider, one quotient bit per cycle, with
//          signed fix-up and divide-by-zero result applied on the outputs.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hilo_div
  import pipe_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_start,
  input  wire logic [DATA_W-1:0] i_dividend,
  input  wire logic [DATA_W-1:0] i_divisor,
  input  wire logic              i_signed,
  output logic                   o_done,
  output logic [DATA_W-1:0]      o_quotient,
  output logic [DATA_W-1:0]      o_remainder
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_raw_a;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_dz;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;

  assign w_a_neg = i_signed & i_dividend[DATA_W-1];
  assign w_b_neg = i_signed & i_divisor[DATA_W-1];
  // Dividend bits shift out of r_quo into the remainder as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_raw_a <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= CNT_W'(DATA_W - 1);
      r_quo   <= w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
      r_dvs   <= w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
      r_rem   <= '0;
      r_raw_a <= i_dividend;
      r_q_neg <= w_a_neg ^ w_b_neg;
      r_r_neg <= w_a_neg;
      r_dz    <= (i_divisor == '0);
    end else if (r_run) begin
      if (!w_diff[DATA_W]) begin
        r_rem <= w_diff[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_done      = r_run & (r_cnt == '0);
  assign o_quotient  = r_dz ? '1      : DATA_W'(fix_sign(MAX_W'(r_quo), r_q_neg));
  assign o_remainder = r_dz ? r_raw_a : DATA_W'(fix_sign(MAX_W'(r_rem), r_r_neg));

endmodule
`default_nettype wire

// File: rtl/pipe_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module : pipe_hilo_unit
// Brief  : HI/LO registers, multi-cycle mul/div engine, EX/MEM and MEM/WB
//          writeback muxes, and HI/LO hazard stall.
//          Optional: define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hilo_unit
  import pipe_hilo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 3,
  parameter int LINK_OFS = 8
) (
  input wire logic   clk,
  input wire logic   reset,
  pipe_hilo_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam int W2    = 2 * DATA_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_mem_wb;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic              r_mul_sgn;
  logic [1:0]        r_mul_mode;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_is_hilo_op;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_op_sgn;
  logic [1:0]        w_op_mode;
  logic              w_div_start;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_q;
  logic [DATA_W-1:0] w_div_r;
  logic [W2-1:0]     w_mul_ea;
  logic [W2-1:0]     w_mul_eb;
  logic [W2-1:0]     w_prod;
  logic [W2-1:0]     w_mul_res;
  logic [DATA_W-1:0] w_ex_wb;
  logic              w_busy;

  always_comb begin
    w_is_hilo_op = 1'b0;
    w_is_mul     = 1'b0;
    w_is_div     = 1'b0;
    w_op_sgn     = 1'b0;
    w_op_mode    = MUL_SET;
    case (bus.op)
      OP_MULT:  begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; w_op_sgn = 1'b1; end
      OP_MULTU: begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; end
      OP_DIV:   begin w_is_hilo_op = 1'b1; w_is_div = 1'b1; w_op_sgn = 1'b1; end
      OP_DIVU:  begin w_is_hilo_op = 1'b1; w_is_div = 1'b1; end
      OP_MTHI, OP_MTLO: w_is_hilo_op = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD:  begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; w_op_sgn = 1'b1; w_op_mode = MUL_ADD; end
      OP_MADDU: begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; w_op_mode = MUL_ADD; end
      OP_MSUB:  begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; w_op_sgn = 1'b1; w_op_mode = MUL_SUB; end
      OP_MSUBU: begin w_is_hilo_op = 1'b1; w_is_mul = 1'b1; w_op_mode = MUL_SUB; end
`endif
      default: ;
    endcase
  end

  assign w_accept = bus.op_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = ST_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = ST_DIV;
          w_div_start = 1'b1;
        end
      end
      ST_MUL:  if (r_cnt == '0) w_state_nxt = ST_IDLE;
      ST_DIV:  if (w_div_done) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign-extending to 2*DATA_W makes the truncated product correct for both signednesses.
  assign w_mul_ea = {{DATA_W{r_mul_sgn & r_mul_a[DATA_W-1]}}, r_mul_a};
  assign w_mul_eb = {{DATA_W{r_mul_sgn & r_mul_b[DATA_W-1]}}, r_mul_b};
  assign w_prod   = w_mul_ea * w_mul_eb;

  always_comb begin
    case (r_mul_mode)
      MUL_ADD: w_mul_res = {r_hi, r_lo} + w_prod;
      MUL_SUB: w_mul_res = {r_hi, r_lo} - w_prod;
      default: w_mul_res = w_prod;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mem_wb   <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_sgn  <= 1'b0;
      r_mul_mode <= MUL_SET;
      r_cnt      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_wb <= w_ex_wb;
      if (w_accept) begin
        if (bus.op == OP_MTHI) r_hi <= bus.src_a;
        if (bus.op == OP_MTLO) r_lo <= bus.src_a;
        if (w_is_mul) begin
          r_mul_a    <= bus.src_a;
          r_mul_b    <= bus.src_b;
          r_mul_sgn  <= w_op_sgn;
          r_mul_mode <= w_op_mode;
          r_cnt      <= CNT_W'(MUL_LAT - 1);
        end
      end
      if (r_state == ST_MUL) begin
        if (r_cnt == '0) begin
          {r_hi, r_lo} <= w_mul_res;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (r_state == ST_FIX) begin
        r_lo <= w_div_q;
        r_hi <= w_div_r;
      end
    end
  end

  pipe_hilo_div #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (bus.src_a),
    .i_divisor   (bus.src_b),
    .i_signed    (w_op_sgn),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  always_comb begin
    case (bus.ex_mem_wb_sel)
      WB_ALU:  w_ex_wb = bus.alu_result;
      WB_LINK: w_ex_wb = bus.pc + DATA_W'(LINK_OFS);
      WB_HI:   w_ex_wb = r_hi;
      WB_LO:   w_ex_wb = r_lo;
      default: w_ex_wb = '0;
    endcase
  end

  assign w_busy             = (r_state != ST_IDLE);
  assign bus.busy           = w_busy;
  assign bus.stall          = w_busy & ((bus.op_valid & w_is_hilo_op) |
                                        (bus.ex_mem_wb_sel == WB_HI) |
                                        (bus.ex_mem_wb_sel == WB_LO));
  assign bus.ex_mem_wb_data = w_ex_wb;
  assign bus.mem_wb_data    = bus.mem_wb_sel ? bus.mem_data : r_mem_wb;
  assign bus.hi_out         = r_hi;
  assign bus.lo_out         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hilo_unit
// Brief  : Directed self-checking bench for pipe_hilo_unit (HILO_MADD_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hilo_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_busy;

  pipe_hilo_if #(.DATA_W(32)) bus ();

  pipe_hilo_unit #(
    .DATA_W   (32),
    .MUL_LAT  (3),
    .LINK_OFS (8)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
  endtask

  // Counts busy cycles after an accept edge; bounded so a stuck engine still ends.
  task automatic wait_idle();
    n_busy = 0;
    while (bus.busy && n_busy < 200) begin
      n_busy++;
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.op_valid      = 1'b0;
    bus.op            = 4'd0;
    bus.src_a         = '0;
    bus.src_b         = '0;
    bus.ex_mem_wb_sel = 3'd0;
    bus.alu_result    = '0;
    bus.pc            = '0;
    bus.mem_wb_sel    = 1'b0;
    bus.mem_data      = '0;
    tick();
    tick();
    chk("rst_hi",    bus.hi_out, 32'h0);
    chk("rst_lo",    bus.lo_out, 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    rst_n = 1'b1;
    tick();

    issue(4'd5, 32'h0000_AAAA, 32'h0);
    chk("mthi_hi",   bus.hi_out, 32'h0000_AAAA);
    chk("mthi_busy", 32'(bus.busy), 32'h0);

    issue(4'd1, 32'hFFFF_FFFE, 32'h3);
    wait_idle();
    chk("mult_lat", 32'(n_busy), 32'd3);
    chk("mult_hi",  bus.hi_out, 32'hFFFF_FFFF);
    chk("mult_lo",  bus.lo_out, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFE, 32'h3);
    wait_idle();
    chk("multu_hi", bus.hi_out, 32'h0000_0002);
    chk("multu_lo", bus.lo_out, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'h2);
    wait_idle();
    chk("div_lat", 32'(n_busy), 32'd33);
    chk("div_lo",  bus.lo_out, 32'hFFFF_FFFD);
    chk("div_hi",  bus.hi_out, 32'hFFFF_FFFF);

    issue(4'd4, 32'h7, 32'h0);
    wait_idle();
    chk("divz_lat", 32'(n_busy), 32'd33);
    chk("divz_lo",  bus.lo_out, 32'hFFFF_FFFF);
    chk("divz_hi",  bus.hi_out, 32'h0000_0007);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("divmin_lo", bus.lo_out, 32'h8000_0000);
    chk("divmin_hi", bus.hi_out, 32'h0);

    issue(4'd2, 32'h0001_0000, 32'h0003_0000);
    bus.ex_mem_wb_sel = 3'd3;
    #1;
    chk("stall_c1", 32'(bus.stall), 32'h1);
    tick();
    chk("stall_c2", 32'(bus.stall), 32'h1);
    tick();
    chk("stall_c3", 32'(bus.stall), 32'h1);
    tick();
    chk("stall_end",  32'(bus.stall), 32'h0);
    chk("mfhi_value", bus.ex_mem_wb_data, 32'h0000_0003);

    bus.ex_mem_wb_sel = 3'd0;
    bus.alu_result    = 32'h0000_1111;
    #1;
    chk("mux_alu", bus.ex_mem_wb_data, 32'h0000_1111);
    bus.ex_mem_wb_sel = 3'd2;
    bus.pc            = 32'hFFFF_FFFC;
    #1;
    chk("mux_link", bus.ex_mem_wb_data, 32'h0000_0004);
    tick();
    bus.ex_mem_wb_sel = 3'd5;
    #1;
    chk("mux_sel5",  bus.ex_mem_wb_data, 32'h0);
    chk("memwb_reg", bus.mem_wb_data, 32'h0000_0004);
    bus.mem_wb_sel = 1'b1;
    bus.mem_data   = 32'h0000_DEAD;
    #1;
    chk("memwb_mem", bus.mem_wb_data, 32'h0000_DEAD);
    bus.mem_wb_sel    = 1'b0;
    bus.ex_mem_wb_sel = 3'd0;

    issue(4'd2, 32'h2, 32'h2);
    bus.op       = 4'd9;
    bus.op_valid = 1'b1;
    #1;
`ifdef HILO_MADD_EN
    chk("madd_busy_stall", 32'(bus.stall), 32'h1);
`else
    chk("madd_off_stall", 32'(bus.stall), 32'h0);
`endif
    tick();
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
    wait_idle();
    chk("multu4_lo", bus.lo_out, 32'h4);

    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0);
    issue(4'd9, 32'h1, 32'h1);
`ifdef HILO_MADD_EN
    wait_idle();
    chk("maddu_lat", 32'(n_busy), 32'd3);
    chk("maddu_hi",  bus.hi_out, 32'h1);
    chk("maddu_lo",  bus.lo_out, 32'h0);
`else
    chk("maddu_off_busy", 32'(bus.busy), 32'h0);
    chk("maddu_off_hi",   bus.hi_out, 32'h0);
    chk("maddu_off_lo",   bus.lo_out, 32'hFFFF_FFFF);
`endif

    issue(4'd5, 32'h0000_5555, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    repeat (5) tick();
    chk("middiv_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_hi",   bus.hi_out, 32'h0);
    chk("arst_lo",   bus.lo_out, 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(4'd6, 32'h0000_1234, 32'h0);
    chk("post_rst_lo", bus.lo_out, 32'h0000_1234);
    chk("post_rst_hi", bus.hi_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
